// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master and its lane aligner.
package lsu_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] { SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2 } size_e;
  typedef enum logic [1:0] { ST_IDLE, ST_ACC0, ST_ACC1, ST_RESP } state_e;

  // Byte lanes touched by an access: bits 3:0 = addressed word, bits 7:4 = following word.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'h00;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store merge into one memory word, load extract and extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic        hi_sel,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  mask;
  logic [63:0] wshift;
  logic [3:0]  word_mask;
  logic [31:0] word_data;
  logic [31:0] rshift;

  assign mask      = lane_mask(size, offset);
  assign wshift    = {32'h0, wdata} << {offset, 3'b000};
  assign word_mask = hi_sel ? mask[7:4] : mask[3:0];
  assign word_data = hi_sel ? wshift[63:32] : wshift[31:0];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = word_mask[gi] ? word_data[8*gi +: 8] : rdata[8*gi +: 8];
    end
  endgenerate

  // Little-endian pair {hi,lo}; the addressed byte ends up in bits 7:0.
  assign rshift = 32'({hi_word, lo_word} >> {offset, 3'b000});

  always_comb begin
    load_data = rshift;
    case (size)
      SZ_B:    load_data = {{24{~is_unsigned & rshift[7]}}, rshift[7:0]};
      SZ_H:    load_data = {{16{~is_unsigned & rshift[15]}}, rshift[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: byte/half/word core requests to word-wide memory accesses.
// MISALIGN_SPLIT_EN: when defined, word-crossing accesses run as two word accesses.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

  state_e            state_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic [1:0]        off_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       lo_buf_reg;
  logic [31:0]       wdata_hold_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              mem_write_reg;
  logic              resp_valid_reg;
  logic              resp_err_reg;
  logic [31:0]       resp_rdata_reg;

  logic [1:0]        last_off;
  logic [ADDR_W:0]   req_end;
  logic              align_err;
  logic              req_err;
  logic              split_need;
  logic              in_acc1;
  logic [31:0]       lo_word;
  logic [31:0]       merged;
  logic [31:0]       load_data;

  always_comb begin
    case (req_size)
      SZ_B:    last_off = 2'd0;
      SZ_H:    last_off = 2'd1;
      default: last_off = 2'd3;
    endcase
  end

  // One extra bit so an access wrapping past the top of the address space fails the range check.
  assign req_end = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, last_off};

`ifdef MISALIGN_SPLIT_EN
  logic [7:0] acc_mask;
  assign align_err  = 1'b0;
  assign acc_mask   = lane_mask(size_reg, off_reg);
  assign split_need = |acc_mask[7:4];
`else
  assign align_err  = (req_size == SZ_H && req_addr[0]) ||
                      (req_size == SZ_W && req_addr[1:0] != 2'b00);
  assign split_need = 1'b0;
`endif

  assign req_err = (req_size == 2'd3) || (req_end >= MEM_LIMIT) || align_err;

  assign in_acc1 = (state_reg == ST_ACC1);
  assign lo_word = in_acc1 ? lo_buf_reg : mem_rdata;

  lsu_align u_align (
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .offset      (off_reg),
    .hi_sel      (in_acc1),
    .wdata       (wdata_reg),
    .rdata       (mem_rdata),
    .lo_word     (lo_word),
    .hi_word     (mem_rdata),
    .merged      (merged),
    .load_data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      we_reg         <= 1'b0;
      size_reg       <= 2'd0;
      uns_reg        <= 1'b0;
      off_reg        <= 2'd0;
      wdata_reg      <= 32'h0;
      lo_buf_reg     <= 32'h0;
      wdata_hold_reg <= 32'h0;
      mem_addr_reg   <= '0;
      mem_write_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            size_reg  <= req_size;
            uns_reg   <= req_unsigned;
            off_reg   <= req_addr[1:0];
            wdata_reg <= req_wdata;
            if (req_err) begin
              state_reg      <= ST_RESP;
              resp_valid_reg <= 1'b1;
              resp_err_reg   <= 1'b1;
              resp_rdata_reg <= 32'h0;
            end else begin
              state_reg     <= ST_ACC0;
              mem_addr_reg  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_write_reg <= req_we;
            end
          end
        end
        ST_ACC0, ST_ACC1: begin
          if (we_reg) wdata_hold_reg <= merged;
          else        lo_buf_reg     <= mem_rdata;
          if (state_reg == ST_ACC0 && split_need) begin
            state_reg    <= ST_ACC1;
            mem_addr_reg <= mem_addr_reg + ADDR_W'(WORD_BYTES);
          end else begin
            state_reg      <= ST_RESP;
            mem_write_reg  <= 1'b0;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= we_reg ? 32'h0 : load_data;
          end
        end
        ST_RESP: begin
          state_reg      <= ST_IDLE;
          resp_valid_reg <= 1'b0;
          resp_err_reg   <= 1'b0;
          resp_rdata_reg <= 32'h0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_write  = mem_write_reg;
  // Merged word is only live while writing; otherwise hold the last word written.
  assign mem_wdata  = mem_write_reg ? merged : wdata_hold_reg;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Table-driven bench for lsu_mem_master with a behavioural word memory (4 KiB).
module tb_lsu_mem_master;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_write;
  logic [31:0]       mem_rdata;

  logic [31:0] mem [0:1023];
  logic        mem_init = 1'b1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(ADDR_W), .MEM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[9]    <= 32'h55667788;
      mem[12]   <= 32'h11111111;
      mem[13]   <= 32'h22222222;
      mem[16]   <= 32'h01020304;
      mem[17]   <= 32'h05060708;
      mem[1023] <= 32'hCAFEF00D;
    end else if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          wr;
    int          idx;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rd, input logic err, input int lat,
                     input int wr, input int idx, input logic [31:0] word);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.err = err; v.lat = lat; v.wr = wr; v.idx = idx; v.word = word;
    vecs.push_back(v);
  endtask

  // Issue one request; report response latency (cycles after accept), data, error and writes seen.
  task automatic run_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic e, output int wr);
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = 32'h0; e = 1'b0; wr = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_write) wr++;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; e = resp_err;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          wr;
    logic [31:0] rd;
    logic        e;
    logic        seen;

    // we size uns addr wdata | rdata err lat writes | mem word index, expected word
    add(1, 2, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2, 1, 4,    32'hDEADBEEF);
    add(0, 2, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2, 0, 4,    32'hDEADBEEF);
    add(1, 2, 0, 32'h20,   32'h11223344, 32'h0,        0, 2, 1, 8,    32'h11223344);
    add(1, 0, 0, 32'h21,   32'h123456AA, 32'h0,        0, 2, 1, 8,    32'h1122AA44);
    add(0, 0, 0, 32'h21,   32'h0,        32'hFFFFFFAA, 0, 2, 0, 8,    32'h1122AA44);
    add(0, 0, 1, 32'h21,   32'h0,        32'h000000AA, 0, 2, 0, 8,    32'h1122AA44);
    add(0, 2, 0, 32'h20,   32'h0,        32'h1122AA44, 0, 2, 0, 8,    32'h1122AA44);
    add(1, 1, 0, 32'h22,   32'h0000BEEF, 32'h0,        0, 2, 1, 8,    32'hBEEFAA44);
    add(0, 1, 0, 32'h22,   32'h0,        32'hFFFFBEEF, 0, 2, 0, 8,    32'hBEEFAA44);
    add(0, 1, 1, 32'h22,   32'h0,        32'h0000BEEF, 0, 2, 0, 8,    32'hBEEFAA44);
    add(0, 1, 0, 32'h20,   32'h0,        32'hFFFFAA44, 0, 2, 0, 8,    32'hBEEFAA44);
    add(0, 0, 1, 32'h23,   32'h0,        32'h000000BE, 0, 2, 0, 8,    32'hBEEFAA44);
    add(0, 2, 0, 32'hFFC,  32'h0,        32'hCAFEF00D, 0, 2, 0, 1023, 32'hCAFEF00D);
    add(0, 2, 0, 32'h1000, 32'h0,        32'h0,        1, 1, 0, 1023, 32'hCAFEF00D);
    add(0, 3, 0, 32'h10,   32'h0,        32'h0,        1, 1, 0, 4,    32'hDEADBEEF);
    add(1, 3, 0, 32'h10,   32'h0,        32'h0,        1, 1, 0, 4,    32'hDEADBEEF);
    add(1, 0, 0, 32'hFFF,  32'h0000005A, 32'h0,        0, 2, 1, 1023, 32'h5AFEF00D);
    add(1, 2, 0, 32'hFFE,  32'h99999999, 32'h0,        1, 1, 0, 1023, 32'h5AFEF00D);
`ifdef MISALIGN_SPLIT_EN
    add(0, 1, 1, 32'h21,   32'h0,        32'h0000EFAA, 0, 2, 0, 8,    32'hBEEFAA44);
    add(0, 2, 0, 32'h22,   32'h0,        32'h7788BEEF, 0, 3, 0, 9,    32'h55667788);
    add(1, 1, 0, 32'h33,   32'h0000BEEF, 32'h0,        0, 3, 2, 12,   32'hEF111111);
    add(0, 0, 1, 32'h34,   32'h0,        32'h000000BE, 0, 2, 0, 13,   32'h222222BE);
    add(1, 2, 0, 32'h3,    32'hCAFEBABE, 32'h0,        0, 3, 2, 0,    32'hBE000000);
    add(0, 2, 0, 32'h4,    32'h0,        32'h00CAFEBA, 0, 2, 0, 1,    32'h00CAFEBA);
`else
    add(0, 1, 1, 32'h21,   32'h0,        32'h0,        1, 1, 0, 8,    32'hBEEFAA44);
    add(0, 2, 0, 32'h22,   32'h0,        32'h0,        1, 1, 0, 9,    32'h55667788);
    add(1, 1, 0, 32'h33,   32'h0000BEEF, 32'h0,        1, 1, 0, 12,   32'h11111111);
    add(0, 0, 1, 32'h34,   32'h0,        32'h00000022, 0, 2, 0, 13,   32'h22222222);
    add(1, 2, 0, 32'h3,    32'hCAFEBABE, 32'h0,        1, 1, 0, 0,    32'h00000000);
    add(0, 2, 0, 32'h4,    32'h0,        32'h0,        0, 2, 0, 1,    32'h00000000);
`endif

    // Reset state, with the memory preload running underneath.
    repeat (3) @(negedge clk);
    check("rst_req_ready",  {31'b0, req_ready},  32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata,          32'h0);
    check("rst_resp_err",   {31'b0, resp_err},   32'h0);
    check("rst_mem_write",  {31'b0, mem_write},  32'h0);
    check("rst_mem_addr",   mem_addr,            32'h0);
    check("rst_mem_wdata",  mem_wdata,           32'h0);
    mem_init = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, lat, rd, e, wr);
      $display("txn %0d we=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d writes=%0d",
               i, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, lat, rd, e, wr);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_err", i),     {31'b0, e}, {31'b0, vecs[i].err});
      check($sformatf("v%0d_rdata", i),   rd, vecs[i].rd);
      check($sformatf("v%0d_writes", i),  32'(wr), 32'(vecs[i].wr));
      check($sformatf("v%0d_memword", i), mem[vecs[i].idx], vecs[i].word);
    end

    // Illegal size with req_valid held through RESP: no second accept, nothing written.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 32'h80;
    @(posedge clk);
    @(negedge clk);
    check("hold_resp_valid", {31'b0, resp_valid}, 32'h1);
    check("hold_resp_err",   {31'b0, resp_err},   32'h1);
    check("hold_req_ready",  {31'b0, req_ready},  32'h0);
    req_we = 1'b1; req_size = 2'd2; req_wdata = 32'h99999999;
    @(negedge clk);
    req_valid = 1'b0;
    check("hold_idle_after", {31'b0, req_ready}, 32'h1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_write || resp_valid) seen = 1'b1;
    end
    check("hold_no_activity", {31'b0, seen}, 32'h0);
    check("hold_mem_word",    mem[32],       32'h0);
    $display("txn hold-valid-in-resp: no accept, mem[0x80]=%h", mem[32]);

    // Reset in the middle of a store: no response, uncommitted word untouched.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_wdata = 32'hA1B2C3D4;
`ifdef MISALIGN_SPLIT_EN
    req_addr = 32'h41;
`else
    req_addr = 32'h40;
`endif
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_acc0_write", {31'b0, mem_write}, 32'h1);
`ifdef MISALIGN_SPLIT_EN
    @(negedge clk);
    check("rst_mid_acc1_write", {31'b0, mem_write}, 32'h1);
`endif
    rst_n = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid || mem_write) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid || mem_write) seen = 1'b1;
    end
    check("rst_mid_no_resp",  {31'b0, seen},      32'h0);
    check("rst_mid_ready",    {31'b0, req_ready}, 32'h1);
`ifdef MISALIGN_SPLIT_EN
    check("rst_mid_word0",    mem[16], 32'hB2C3D404);
`else
    check("rst_mid_word0",    mem[16], 32'h01020304);
`endif
    check("rst_mid_word1",    mem[17], 32'h05060708);
    $display("txn reset-mid-store: word0=%h word1=%h", mem[16], mem[17]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
